// File: rtl/plat_collide_scan_pkg.sv
// Shared game package: geometry constants for the platform/block generator and
// the landing-scan FSM encoding.
package plat_collide_scan_pkg;

   localparam int PlatformNumPerBlock = 7;    // platforms per block
   localparam int PhyWidth            = 16;   // coordinate width
   localparam int CameraWidth         = 6;    // block-index width
   localparam int BlockWidth          = 480;  // block height in pixels
   localparam int BlockLenWidth       = 4;    // platform length field width
   localparam int TileW               = 8;    // pixels per length unit
   localparam int CharW               = 16;   // character width in pixels

   typedef enum logic {
      StIdle = 1'b0,
      StScan = 1'b1
   } scan_state_e;

endpackage

// File: rtl/plat_hit_check.sv
// Combinational landing test for one platform slot.
// Ports:
//   char_x    - character left edge (absolute)
//   foot_prev - character foot y this frame (signed, y grows upward)
//   foot_next - character foot y proposed next frame (signed)
//   plat_x    - platform left edge
//   plat_top  - absolute platform top y (block base + relative y)
//   plat_len  - platform length in tiles; zero means an empty slot
//   hit       - character crosses the platform top while overlapping it horizontally
module plat_hit_check
   import plat_collide_scan_pkg::*;
#(
   parameter int PHY_WIDTH       = PhyWidth,
   parameter int BLOCK_LEN_WIDTH = BlockLenWidth,
   parameter int TILE_W          = TileW,
   parameter int CHAR_W          = CharW
) (
   input  logic        [PHY_WIDTH-1:0]       char_x,
   input  logic signed [PHY_WIDTH:0]         foot_prev,
   input  logic signed [PHY_WIDTH:0]         foot_next,
   input  logic        [PHY_WIDTH-1:0]       plat_x,
   input  logic signed [PHY_WIDTH+1:0]       plat_top,
   input  logic        [BLOCK_LEN_WIDTH-1:0] plat_len,
   output logic                              hit
);

   // Two guard bits so x + width and base + y never wrap.
   localparam int ExtW = PHY_WIDTH + 2;

   logic signed [ExtW-1:0] cx;
   logic signed [ExtW-1:0] cx_end;
   logic signed [ExtW-1:0] px;
   logic signed [ExtW-1:0] px_end;
   logic signed [ExtW-1:0] len_ext;
   logic signed [ExtW-1:0] fp;
   logic signed [ExtW-1:0] fn;

   assign cx      = signed'({2'b00, char_x});
   assign cx_end  = cx + ExtW'(CHAR_W);
   assign px      = signed'({2'b00, plat_x});
   assign len_ext = signed'({{(ExtW-BLOCK_LEN_WIDTH){1'b0}}, plat_len});
   assign px_end  = px + len_ext * ExtW'(TILE_W);
   assign fp      = {foot_prev[PHY_WIDTH], foot_prev};
   assign fn      = {foot_next[PHY_WIDTH], foot_next};

   assign hit = (plat_len != '0) && (cx_end > px) && (cx < px_end) &&
                (fp >= plat_top) && (fn <= plat_top);

endmodule

// File: rtl/plat_collide_scan.sv
// Sequential landing scan over the platforms of the current block. A start in
// idle snapshots all inputs, then one slot per cycle is tested; the highest
// hitting platform top wins (lowest slot on ties).
// Ports:
//   sys_clk, sys_rst_n - clock, asynchronous active-low reset
//   start              - one-cycle scan request (ignored while busy)
//   char_x             - character left edge
//   foot_prev/next     - character foot y, this frame / proposed next frame
//   camera_y           - current block index
//   plat_relative_x/y  - packed platform origins, slot i at bits i*PHY_WIDTH
//   plat_len           - packed platform lengths in tiles
//   busy               - scan in progress
//   done               - one-cycle result-valid pulse
//   hit, hit_idx       - landing found / winning slot
//   land_y             - winning platform top, or foot_next on a miss
module plat_collide_scan
   import plat_collide_scan_pkg::*;
#(
   parameter int PLATFORM_NUM_PER_BLOCK = PlatformNumPerBlock,
   parameter int PHY_WIDTH              = PhyWidth,
   parameter int CAMERA_WIDTH           = CameraWidth,
   parameter int BLOCK_WIDTH            = BlockWidth,
   parameter int BLOCK_LEN_WIDTH        = BlockLenWidth,
   parameter int TILE_W                 = TileW,
   parameter int CHAR_W                 = CharW
) (
   input  logic                                              sys_clk,
   input  logic                                              sys_rst_n,
   input  logic                                              start,
   input  logic        [PHY_WIDTH-1:0]                       char_x,
   input  logic signed [PHY_WIDTH:0]                         foot_prev,
   input  logic signed [PHY_WIDTH:0]                         foot_next,
   input  logic        [CAMERA_WIDTH-1:0]                    camera_y,
   input  logic        [PLATFORM_NUM_PER_BLOCK*PHY_WIDTH-1:0]       plat_relative_x,
   input  logic        [PLATFORM_NUM_PER_BLOCK*PHY_WIDTH-1:0]       plat_relative_y,
   input  logic        [PLATFORM_NUM_PER_BLOCK*BLOCK_LEN_WIDTH-1:0] plat_len,
   output logic                                              busy,
   output logic                                              done,
   output logic                                              hit,
   output logic        [2:0]                                 hit_idx,
   output logic signed [PHY_WIDTH:0]                         land_y
);

   localparam int ExtW = PHY_WIDTH + 2;
   localparam logic [2:0] LastSlot = 3'(PLATFORM_NUM_PER_BLOCK - 1);

   scan_state_e state_q, state_d;
   logic [2:0]  slot_q, slot_d;

   // Input snapshot taken on an accepted start.
   logic                                              snap_en;
   logic        [PHY_WIDTH-1:0]                       char_x_q;
   logic signed [PHY_WIDTH:0]                         foot_prev_q, foot_next_q;
   logic        [ExtW-1:0]                            base_y_q, base_y_d;
   logic        [PLATFORM_NUM_PER_BLOCK*PHY_WIDTH-1:0]       plat_x_q, plat_y_q;
   logic        [PLATFORM_NUM_PER_BLOCK*BLOCK_LEN_WIDTH-1:0] plat_len_q;

   // Running best candidate across the slots scanned so far.
   logic                   best_hit_q, best_hit_d;
   logic [2:0]             best_idx_q, best_idx_d;
   logic signed [ExtW-1:0] best_top_q, best_top_d;

   logic                     done_q, done_d;
   logic                     hit_q, hit_d;
   logic [2:0]               hit_idx_q, hit_idx_d;
   logic signed [PHY_WIDTH:0] land_y_q, land_y_d;

   // Slot multiplexer feeding the single hit checker.
   logic [PHY_WIDTH-1:0]       slot_x;
   logic [PHY_WIDTH-1:0]       slot_y;
   logic [BLOCK_LEN_WIDTH-1:0] slot_len;
   logic signed [ExtW-1:0]     slot_top;
   logic                       slot_hit;

   assign slot_x   = plat_x_q[slot_q*PHY_WIDTH +: PHY_WIDTH];
   assign slot_y   = plat_y_q[slot_q*PHY_WIDTH +: PHY_WIDTH];
   assign slot_len = plat_len_q[slot_q*BLOCK_LEN_WIDTH +: BLOCK_LEN_WIDTH];
   assign slot_top = signed'(base_y_q + {2'b00, slot_y});

   assign base_y_d = {{(ExtW-CAMERA_WIDTH){1'b0}}, camera_y} * ExtW'(BLOCK_WIDTH);

   plat_hit_check #(
      .PHY_WIDTH       (PHY_WIDTH),
      .BLOCK_LEN_WIDTH (BLOCK_LEN_WIDTH),
      .TILE_W          (TILE_W),
      .CHAR_W          (CHAR_W)
   ) u_hit_check (
      .char_x    (char_x_q),
      .foot_prev (foot_prev_q),
      .foot_next (foot_next_q),
      .plat_x    (slot_x),
      .plat_top  (slot_top),
      .plat_len  (slot_len),
      .hit       (slot_hit)
   );

   logic                   cand_better;
   logic                   nb_hit;
   logic [2:0]             nb_idx;
   logic signed [ExtW-1:0] nb_top;

   always_comb begin
      // Strictly greater replaces, so the lower slot keeps an equal top.
      cand_better = slot_hit && (!best_hit_q || (slot_top > best_top_q));
      nb_hit      = best_hit_q | slot_hit;
      nb_idx      = cand_better ? slot_q : best_idx_q;
      nb_top      = cand_better ? slot_top : best_top_q;

      state_d    = state_q;
      slot_d     = slot_q;
      snap_en    = 1'b0;
      best_hit_d = best_hit_q;
      best_idx_d = best_idx_q;
      best_top_d = best_top_q;
      done_d     = 1'b0;
      hit_d      = hit_q;
      hit_idx_d  = hit_idx_q;
      land_y_d   = land_y_q;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d    = StScan;
               slot_d     = '0;
               snap_en    = 1'b1;
               best_hit_d = 1'b0;
               best_idx_d = '0;
               best_top_d = '0;
            end
         end
         StScan: begin
            best_hit_d = nb_hit;
            best_idx_d = nb_idx;
            best_top_d = nb_top;
            slot_d     = slot_q + 3'd1;
            if (slot_q == LastSlot) begin
               state_d   = StIdle;
               done_d    = 1'b1;
               hit_d     = nb_hit;
               hit_idx_d = nb_hit ? nb_idx : 3'd0;
               land_y_d  = nb_hit ? nb_top[PHY_WIDTH:0] : foot_next_q;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q    <= StIdle;
         slot_q     <= '0;
         best_hit_q <= 1'b0;
         best_idx_q <= '0;
         best_top_q <= '0;
         done_q     <= 1'b0;
         hit_q      <= 1'b0;
         hit_idx_q  <= '0;
         land_y_q   <= '0;
      end else begin
         state_q    <= state_d;
         slot_q     <= slot_d;
         best_hit_q <= best_hit_d;
         best_idx_q <= best_idx_d;
         best_top_q <= best_top_d;
         done_q     <= done_d;
         hit_q      <= hit_d;
         hit_idx_q  <= hit_idx_d;
         land_y_q   <= land_y_d;
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         char_x_q    <= '0;
         foot_prev_q <= '0;
         foot_next_q <= '0;
         base_y_q    <= '0;
         plat_x_q    <= '0;
         plat_y_q    <= '0;
         plat_len_q  <= '0;
      end else if (snap_en) begin
         char_x_q    <= char_x;
         foot_prev_q <= foot_prev;
         foot_next_q <= foot_next;
         base_y_q    <= base_y_d;
         plat_x_q    <= plat_relative_x;
         plat_y_q    <= plat_relative_y;
         plat_len_q  <= plat_len;
      end
   end

   assign busy    = (state_q == StScan);
   assign done    = done_q;
   assign hit     = hit_q;
   assign hit_idx = hit_idx_q;
   assign land_y  = land_y_q;

endmodule

// File: tb/tb_plat_collide_scan.sv
module tb_plat_collide_scan;

   localparam int N  = 7;
   localparam int PW = 16;
   localparam int LW = 4;

   logic                     sys_clk = 1'b0;
   logic                     sys_rst_n = 1'b0;
   logic                     start = 1'b0;
   logic        [PW-1:0]     char_x = '0;
   logic signed [PW:0]       foot_prev = '0;
   logic signed [PW:0]       foot_next = '0;
   logic        [5:0]        camera_y = '0;
   logic        [N*PW-1:0]   plat_relative_x = '0;
   logic        [N*PW-1:0]   plat_relative_y = '0;
   logic        [N*LW-1:0]   plat_len = '0;
   logic                     busy;
   logic                     done;
   logic                     hit;
   logic        [2:0]        hit_idx;
   logic signed [PW:0]       land_y;

   plat_collide_scan dut (
      .sys_clk         (sys_clk),
      .sys_rst_n       (sys_rst_n),
      .start           (start),
      .char_x          (char_x),
      .foot_prev       (foot_prev),
      .foot_next       (foot_next),
      .camera_y        (camera_y),
      .plat_relative_x (plat_relative_x),
      .plat_relative_y (plat_relative_y),
      .plat_len        (plat_len),
      .busy            (busy),
      .done            (done),
      .hit             (hit),
      .hit_idx         (hit_idx),
      .land_y          (land_y)
   );

   always #5 sys_clk = ~sys_clk;

   int cyc = 0;
   always @(posedge sys_clk) cyc <= cyc + 1;

   typedef struct {
      logic              hit;
      logic [2:0]        idx;
      logic signed [PW:0] land;
      int                cyc;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Monitor: every done pulse must match the oldest pending expectation.
   always @(negedge sys_clk) begin
      if (sys_rst_n && done) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("done_cycle", cyc, e.cyc);
            check("hit", int'(hit), int'(e.hit));
            check("hit_idx", int'(hit_idx), int'(e.idx));
            check("land_y", int'(land_y), int'(e.land));
         end
      end
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge sys_clk);
      #1;
   endtask

   task automatic set_slot(input int i, input int x, input int y, input int l);
      plat_relative_x[i*PW +: PW] = PW'(x);
      plat_relative_y[i*PW +: PW] = PW'(y);
      plat_len[i*LW +: LW]        = LW'(l);
   endtask

   task automatic clear_plats();
      plat_relative_x = '0;
      plat_relative_y = '0;
      plat_len        = '0;
   endtask

   task automatic set_char(input int x, input int fp, input int fn, input int cam);
      char_x    = PW'(x);
      foot_prev = (PW+1)'(fp);
      foot_next = (PW+1)'(fn);
      camera_y  = 6'(cam);
   endtask

   // Called 1 time unit after an edge: start is sampled at the next edge (N),
   // so done is expected after edge N+7.
   task automatic start_scan(input logic h, input int idx, input int land);
      exp_t e;
      e.hit  = h;
      e.idx  = 3'(idx);
      e.land = (PW+1)'(land);
      e.cyc  = cyc + 8;
      sb.push_back(e);
      start = 1'b1;
      @(posedge sys_clk);
      #1;
      start = 1'b0;
   endtask

   task automatic run(input logic h, input int idx, input int land);
      start_scan(h, idx, land);
      wait_cyc(8);
   endtask

   initial begin
      wait_cyc(3);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_hit", int'(hit), 0);
      check("rst_land_y", int'(land_y), 0);
      sys_rst_n = 1'b1;
      wait_cyc(2);

      // Basic hit in block 0, then an immediately re-accepted start in the done cycle.
      clear_plats();
      set_slot(0, 280, 35, 10);
      set_char(300, 40, 30, 0);
      start_scan(1'b1, 0, 35);
      check("busy_during_scan", int'(busy), 1);
      wait_cyc(7);
      set_char(300, 520, 510, 1);
      start_scan(1'b1, 0, 515);
      wait_cyc(8);
      check("busy_after_done", int'(busy), 0);
      set_char(300, 540, 530, 1);
      run(1'b0, 0, 530);

      // Equal tops: lower slot wins; higher top wins.
      clear_plats();
      set_slot(5, 280, 380, 10);
      set_slot(6, 280, 380, 10);
      set_char(300, 385, 370, 0);
      run(1'b1, 5, 380);
      set_slot(5, 280, 375, 10);
      run(1'b1, 6, 380);

      // Horizontal edges, empty slot and a negative next foot.
      clear_plats();
      set_slot(0, 280, 35, 10);
      set_char(360, 40, 30, 0);
      run(1'b0, 0, 30);
      set_char(264, 40, 30, 0);
      run(1'b0, 0, 30);
      set_char(359, 40, 30, 0);
      run(1'b1, 0, 35);
      set_char(265, 40, 30, 0);
      run(1'b1, 0, 35);
      set_slot(0, 280, 35, 0);
      set_char(270, 40, 30, 0);
      run(1'b0, 0, 30);
      set_slot(0, 280, 35, 10);
      set_char(300, 40, -5, 0);
      run(1'b1, 0, 35);

      // Snapshot isolation and ignored start while busy.
      set_char(300, 40, 30, 0);
      start_scan(1'b1, 0, 35);
      wait_cyc(1);
      clear_plats();
      set_char(0, 0, 0, 1);
      wait_cyc(1);
      start = 1'b1;
      wait_cyc(1);
      start = 1'b0;
      wait_cyc(8);

      // Reset in the middle of a scan discards it.
      set_slot(0, 280, 35, 10);
      set_char(300, 40, 30, 0);
      start_scan(1'b1, 0, 35);
      wait_cyc(3);
      sys_rst_n = 1'b0;
      sb.delete();
      #1;
      check("midrst_busy", int'(busy), 0);
      check("midrst_done", int'(done), 0);
      check("midrst_hit", int'(hit), 0);
      check("midrst_hit_idx", int'(hit_idx), 0);
      check("midrst_land_y", int'(land_y), 0);
      wait_cyc(1);
      sys_rst_n = 1'b1;
      wait_cyc(10);
      check("postrst_hit", int'(hit), 0);
      run(1'b1, 0, 35);

      begin
         int budget = 50;
         while (sb.size() != 0 && budget > 0) begin
            wait_cyc(1);
            budget--;
         end
         if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending results expected 0", sb.size());
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
